// File: rtl/ex_alu_unit_pkg.sv
// Shared definitions for the execute-stage ALU: op codes from the ALU-control
// decoder and the ALU sequencing states.
package ex_alu_unit_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_MUL = 3'b100;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } alu_state_e;

endpackage

// File: rtl/ex_alu_unit_seq_mul.sv
// Iterative shift-add multiplier: one multiplier bit per step, always WIDTH
// steps, producing the low WIDTH bits of the product.
module seq_mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start,
  input  logic             step,
  input  logic [WIDTH-1:0] mcand_in,
  input  logic [WIDTH-1:0] mplier_in,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand, mplier, acc;
  logic [CW-1:0]    count;

  // product already includes the current step's partial add, so on the
  // final step the caller can register it directly.
  assign product = acc + (mplier[0] ? mcand : '0);
  assign done    = step && (count == CW'(WIDTH-1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (start) begin
      mcand  <= mcand_in;
      mplier <= mplier_in;
      acc    <= '0;
      count  <= '0;
    end else if (step) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CW'(1);
    end
  end

endmodule

// File: rtl/ex_alu_unit.sv
// Execute-stage ALU: single-cycle add/sub/or/and, fixed-latency iterative mul,
// registered result/zero with a one-cycle valid pulse toward EX/MEM.
module ex_alu_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [2:0]       ALUCtr,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o
);

  import ex_alu_unit_pkg::*;

  alu_state_e       state, state_n;
  logic             load, mul_start, mul_step, mul_done;
  logic [WIDTH-1:0] res_n, mul_prod;

  assign ready_o  = (state == S_IDLE);
  assign mul_step = (state == S_MUL);

  seq_mul_unit #(.WIDTH(WIDTH)) u_mul (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start     (mul_start),
    .step      (mul_step),
    .mcand_in  (src1_i),
    .mplier_in (src2_i),
    .done      (mul_done),
    .product   (mul_prod)
  );

  always_comb begin
    state_n   = state;
    load      = 1'b0;
    mul_start = 1'b0;
    res_n     = '0;
    case (state)
      S_IDLE: begin
        if (valid_i) begin
          load = 1'b1;
          case (ALUCtr)
            ALU_ADD: res_n = src1_i + src2_i;
            ALU_SUB: res_n = src1_i - src2_i;
            ALU_OR:  res_n = src1_i | src2_i;
            ALU_AND: res_n = src1_i & src2_i;
            ALU_MUL: begin
              load      = 1'b0;
              mul_start = 1'b1;
              state_n   = S_MUL;
            end
            // undefined codes still produce a clean, defined zero result
            default: res_n = '0;
          endcase
        end
      end
      S_MUL: begin
        if (mul_done) begin
          load    = 1'b1;
          res_n   = mul_prod;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      valid_o  <= 1'b0;
      result_o <= '0;
      zero_o   <= 1'b1;
    end else begin
      state   <= state_n;
      valid_o <= load;
      if (load) begin
        result_o <= res_n;
        zero_o   <= (res_n == '0);
      end
    end
  end

endmodule

// File: tb/tb_ex_alu_unit.sv
// Randomized self-checking bench for ex_alu_unit against an arithmetic model.
module tb_ex_alu_unit;

  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         valid_i;
  logic [2:0]   ALUCtr;
  logic [W-1:0] src1_i, src2_i;
  logic         ready_o, valid_o, zero_o;
  logic [W-1:0] result_o;

  int           n_chk  = 0;
  int           n_fail = 0;
  logic [W-1:0] last_res;

  always #5 clk_i = ~clk_i;

  ex_alu_unit #(.WIDTH(W)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ALUCtr   (ALUCtr),
    .src1_i   (src1_i),
    .src2_i   (src2_i),
    .ready_o  (ready_o),
    .valid_o  (valid_o),
    .result_o (result_o),
    .zero_o   (zero_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [63:0] p;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a | b;
      3'd3: return a & b;
      3'd4: begin
        p = 64'(a) * 64'(b);
        return p[W-1:0];
      end
      default: return '0;
    endcase
  endfunction

  // Issue one op at the next edge; for mul, count busy cycles while pushing
  // junk requests that must be ignored.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] exp;
    int lows;
    exp = ref_alu(op, a, b);
    valid_i = 1'b1; ALUCtr = op; src1_i = a; src2_i = b;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    if (op == 3'd4) begin
      lows = 0;
      while (!ready_o && lows < 2*W) begin
        chk("mul_busy_valid", 64'(valid_o), 64'(0));
        valid_i = 1'($urandom_range(0, 1));
        ALUCtr  = 3'($urandom_range(0, 7));
        src1_i  = $urandom;
        src2_i  = $urandom;
        lows++;
        @(posedge clk_i); #1;
      end
      valid_i = 1'b0;
      chk("mul_busy_len", 64'(lows), 64'(W));
    end
    chk("valid_pulse", 64'(valid_o), 64'(1));
    chk("result", 64'(result_o), 64'(exp));
    chk("zero", 64'(zero_o), 64'(exp == '0));
    last_res = exp;
  endtask

  task automatic idle_chk(input int n);
    repeat (n) begin
      @(posedge clk_i); #1;
      chk("idle_valid", 64'(valid_o), 64'(0));
      chk("idle_hold", 64'(result_o), 64'(last_res));
      chk("idle_zero", 64'(zero_o), 64'(last_res == '0));
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 3))
      0: return '0;
      1: return '1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0] op;
    rst_i = 1'b1; valid_i = 1'b0; ALUCtr = '0; src1_i = '0; src2_i = '0;
    last_res = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_ready", 64'(ready_o), 64'(1));
    chk("rst_valid", 64'(valid_o), 64'(0));
    chk("rst_result", 64'(result_o), 64'(0));
    chk("rst_zero", 64'(zero_o), 64'(1));
    rst_i = 1'b0;
    idle_chk(1);

    // directed cases, back-to-back single-cycle ops
    run_op(3'd0, 32'd5, 32'd7);
    run_op(3'd1, 32'd3, 32'd5);
    run_op(3'd2, 32'hF0F0_0000, 32'h0000_0F0F);
    run_op(3'd3, 32'hFF00_FF00, 32'h00FF_00FF);
    idle_chk(2);
    run_op(3'd4, 32'd6, 32'd7);
    idle_chk(1);
    run_op(3'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd4, 32'h1234, 32'd0);
    run_op(3'd0, 32'h8000_0000, 32'h8000_0000);
    run_op(3'd7, $urandom, $urandom);
    run_op(3'd5, 32'd1, 32'd1);
    run_op(3'd6, 32'hFFFF_FFFF, 32'd9);

    // reset in the middle of a mul
    run_op(3'd0, 32'd40, 32'd2);
    valid_i = 1'b1; ALUCtr = 3'd4; src1_i = 32'd9; src2_i = 32'd9;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (9) @(posedge clk_i);
    #1;
    chk("midmul_busy", 64'(ready_o), 64'(0));
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("abort_ready", 64'(ready_o), 64'(1));
    chk("abort_valid", 64'(valid_o), 64'(0));
    chk("abort_result", 64'(result_o), 64'(0));
    chk("abort_zero", 64'(zero_o), 64'(1));
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    last_res = '0;
    idle_chk(W + 2);
    run_op(3'd0, 32'd1, 32'd1);

    // randomized traffic with random idle gaps
    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(0, 5) == 0) ? 3'd4 : 3'($urandom_range(0, 7));
      run_op(op, pick(), pick());
      if ($urandom_range(0, 3) == 0) idle_chk($urandom_range(1, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
